// File: rtl/hw3_serializer.sv
// hw3_serializer: parallel-to-serial feeder for the serial pattern-detector stage.
//
// Accepts WIDTH-bit words over a valid/ready handshake, buffers up to DEPTH of them in a
// small FIFO and shifts them out MSB first, one bit per clock, on o_data. Consecutive
// words are sent gapless. All outputs except o_busy are registered.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit (XOR of all WIDTH
// data bits) after every word's LSB, giving a WIDTH+1 bit frame. Default build: no parity.
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   DEPTH     FIFO entries, not counting the word held in the shift register (>= 1)
//   IDLE_BIT  o_data value while no word is shifting
//
// Ports:
//   i_clk       clock, all logic on posedge
//   i_rst_n     synchronous active-low reset
//   i_word      parallel word to send
//   i_valid     i_word valid; transfer when i_valid && o_ready at posedge
//   o_ready     FIFO can accept a word (registered)
//   o_data      serial bit stream (registered)
//   o_data_vld  high while o_data carries a data or parity bit (registered)
//   o_busy      shifter active or FIFO non-empty
//   o_word_cnt  number of words fully shifted out, wraps at 16 bits
module hw3_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_data,
  output logic             o_data_vld,
  output logic             o_busy,
  output logic [15:0]      o_word_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BitW = $clog2(WIDTH + 1);

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [BitW-1:0] LastIdx = BitW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign push = i_valid && ready_q;
  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Ready reflects occupancy after this edge's push/pop.
    ready_d = (count_d < DepthC);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) begin
      fifo_mem[wr_ptr_q] <= i_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_idx_q, bit_idx_d;
  logic             data_q, data_d;
  logic             vld_q, vld_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             try_load;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    try_load  = 1'b0;
    pop       = 1'b0;
`ifdef SER_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        try_load = 1'b1;
      end
      StShift: begin
        if (bit_idx_q != LastIdx) begin
          // shift_q[WIDTH-1] is the bit on o_data now; the next one sits below it.
          shift_d   = shift_q << 1;
          data_d    = shift_q[WIDTH-2];
          bit_idx_d = bit_idx_q + BitW'(1);
        end else begin
          cnt_d = cnt_q + 16'd1;
`ifdef SER_PARITY_EN
          state_d = StParity;
          data_d  = parity_q;
          vld_d   = 1'b1;
`else
          try_load = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      StParity: begin
        try_load = 1'b1;
      end
`endif
      default: begin
        state_d = StIdle;
        data_d  = IDLE_BIT;
        vld_d   = 1'b0;
      end
    endcase

    // Shared by idle pickup and end-of-frame: load the FIFO head (gapless) or go idle.
    // Only the registered count is looked at, so a word pushed this edge is not bypassed.
    if (try_load) begin
      if (count_q != '0) begin
        pop       = 1'b1;
        state_d   = StShift;
        shift_d   = head;
        data_d    = head[WIDTH-1];
        vld_d     = 1'b1;
        bit_idx_d = '0;
`ifdef SER_PARITY_EN
        parity_d  = ^head;
`endif
      end else begin
        state_d = StIdle;
        data_d  = IDLE_BIT;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= IDLE_BIT;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
`ifdef SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_ready    = ready_q;
  assign o_data     = data_q;
  assign o_data_vld = vld_q;
  assign o_word_cnt = cnt_q;
  assign o_busy     = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_hw3_serializer.sv
// Self-checking bench for hw3_serializer (WIDTH=8, DEPTH=2, IDLE_BIT=0).
// A queue-based reference model predicts the serial stream: accepted words wait in a
// word queue, the word being sent is a queue of remaining frame bits.
module tb_hw3_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_word = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_data;
  logic        o_data_vld;
  logic        o_busy;
  logic [15:0] o_word_cnt;

  hw3_serializer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .IDLE_BIT (1'b0)
  ) u_dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_word     (i_word),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_data_vld (o_data_vld),
    .o_busy     (o_busy),
    .o_word_cnt (o_word_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_words[$];
  bit          m_bits[$];
  bit          m_last[$];
  bit          m_ready = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic valid, input logic [7:0] word);
    bit acc;
    bit b;
    bit lastf;
    logic [7:0] w;
    if (!rst_n) begin
      m_words.delete();
      m_bits.delete();
      m_last.delete();
      m_ready = 1'b0;
      m_cnt   = 16'd0;
    end else begin
      acc = valid && m_ready;
      if (m_bits.size() > 0) begin
        b     = m_bits.pop_front();
        lastf = m_last.pop_front();
        if (lastf) m_cnt = m_cnt + 16'd1;
      end
      // Next frame starts only from words already queued before this edge.
      if (m_bits.size() == 0 && m_words.size() > 0) begin
        w = m_words.pop_front();
        for (int i = WIDTH - 1; i >= 0; i--) begin
          m_bits.push_back(w[i]);
          m_last.push_back(i == 0);
        end
`ifdef SER_PARITY_EN
        m_bits.push_back(^w);
        m_last.push_back(1'b0);
`endif
      end
      if (acc) m_words.push_back(word);
      m_ready = (m_words.size() < DEPTH);
    end
  endtask

  task automatic compare_all();
    bit e_vld;
    bit e_data;
    e_vld  = (m_bits.size() > 0);
    e_data = e_vld ? m_bits[0] : 1'b0;
    check_val("o_data",     32'(o_data),     32'(e_data));
    check_val("o_data_vld", 32'(o_data_vld), 32'(e_vld));
    check_val("o_ready",    32'(o_ready),    32'(m_ready));
    check_val("o_busy",     32'(o_busy),     32'(e_vld || (m_words.size() > 0)));
    check_val("o_word_cnt", 32'(o_word_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input logic rst_n, input logic valid, input logic [7:0] word);
    i_rst_n = rst_n;
    i_valid = valid;
    i_word  = word;
    @(posedge i_clk);
    model_edge(rst_n, valid, word);
    @(negedge i_clk);
    compare_all();
  endtask

  initial begin
    logic [15:0] bits;
    int acc;
    int vld_n;

    // 1. Reset held 3 edges with i_valid asserted
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h5A);
    check_val("t1_ready_rst", 32'(o_ready), 32'd0);
    cycle(1'b1, 1'b0, 8'h00);
    check_val("t1_ready_up", 32'(o_ready), 32'd1);

    // 2. Single word 8'hDA, MSB first, one cycle after the push edge
    cycle(1'b1, 1'b1, 8'hDA);
    bits = '0;
    vld_n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      bits  = {bits[14:0], o_data};
      vld_n += int'(o_data_vld);
    end
    check_val("t2_bits", 32'(bits[7:0]), 32'h0000_00DA);
    check_val("t2_vld_n", 32'(vld_n), 32'd8);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
    check_val("t2_cnt", 32'(o_word_cnt), 32'd1);

    // 3. Back-to-back FF, 00: 16 gapless bits
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'h00);
    bits  = {15'd0, o_data};
    vld_n = int'(o_data_vld);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      bits  = {bits[14:0], o_data};
      vld_n += int'(o_data_vld);
    end
    check_val("t3_bits", 32'(bits), 32'h0000_FF00);
    check_val("t3_vld_n", 32'(vld_n), 32'd16);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
    check_val("t3_cnt", 32'(o_word_cnt), 32'd3);

    // 4. Hold i_valid with distinct words: 3 accepted, then exactly one more
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_ready) acc++;
      cycle(1'b1, 1'b1, 8'(8'h10 + i));
    end
    check_val("t4_acc_first", 32'(acc), 32'd3);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      if (o_ready) acc++;
      cycle(1'b1, 1'b1, 8'(8'h40 + i));
    end
    check_val("t4_acc_next", 32'(acc), 32'd1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'h00);

    // 5. Reset during bit 3 of 8'hA5
    cycle(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check_val("t5_vld", 32'(o_data_vld), 32'd0);
    check_val("t5_data", 32'(o_data), 32'd0);
    check_val("t5_busy", 32'(o_busy), 32'd0);
    check_val("t5_cnt", 32'(o_word_cnt), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00);

`ifdef SER_PARITY_EN
    // 6. Parity frames: DA has 5 ones -> parity 1; C3 has 4 ones -> parity 0
    cycle(1'b1, 1'b1, 8'hDA);
    cycle(1'b1, 1'b1, 8'hC3);
    bits  = {15'd0, o_data};
    vld_n = int'(o_data_vld);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      if (i < 8) bits = {bits[14:0], o_data};
      vld_n += int'(o_data_vld);
    end
    check_val("t6_frame_da", 32'(bits[8:0]), 32'h0000_01B5);
    check_val("t6_vld_n", 32'(vld_n), 32'd18);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(299) != 0), ($urandom_range(99) < 60), 8'($urandom));
    end
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'h00);
    check_val("drain_busy", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
